// File: rtl/wave_src.sv
// Waveform sample source for the DAC driver: address in, scaled sample out two clocks later.
// Optional sine table built only when WAVE_SINE_EN is defined; otherwise waveform 0 is mid-scale.
module wave_src #(
   parameter logic [1:0] DEF_WAVE = 2'd0,
   parameter logic [1:0] DEF_AMP  = 2'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rd_addr,
   input  logic       cfg_req,
   input  logic [1:0] cfg_wave,
   input  logic [1:0] cfg_amp,
   output logic [7:0] rd_data,
   output logic       cfg_pend,
   output logic [1:0] act_wave,
   output logic [1:0] act_amp
);

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        act_wave_q, act_wave_d;
   logic [1:0]        act_amp_q, act_amp_d;
   logic [1:0]        pnd_wave_q, pnd_wave_d;
   logic [1:0]        pnd_amp_q, pnd_amp_d;
   logic [7:0]        prev_addr_q;
   logic              wrap;
   logic [7:0]        raw_s;
   logic signed [7:0] dev_q, dev_d;
   logic [1:0]        amp1_q;
   logic signed [7:0] scaled;
   logic [7:0]        rd_data_q;

`ifdef WAVE_SINE_EN
   // Quarter-wave table, T[i] = round(127*sin(2*pi*(i+0.5)/256)).
   function automatic logic [6:0] sin_quarter(input logic [5:0] idx);
      logic [6:0] t;
      case (idx)
         6'd0:  t = 7'd2;   6'd1:  t = 7'd5;   6'd2:  t = 7'd8;   6'd3:  t = 7'd11;
         6'd4:  t = 7'd14;  6'd5:  t = 7'd17;  6'd6:  t = 7'd20;  6'd7:  t = 7'd23;
         6'd8:  t = 7'd26;  6'd9:  t = 7'd29;  6'd10: t = 7'd32;  6'd11: t = 7'd35;
         6'd12: t = 7'd38;  6'd13: t = 7'd41;  6'd14: t = 7'd44;  6'd15: t = 7'd47;
         6'd16: t = 7'd50;  6'd17: t = 7'd53;  6'd18: t = 7'd56;  6'd19: t = 7'd58;
         6'd20: t = 7'd61;  6'd21: t = 7'd64;  6'd22: t = 7'd67;  6'd23: t = 7'd69;
         6'd24: t = 7'd72;  6'd25: t = 7'd74;  6'd26: t = 7'd77;  6'd27: t = 7'd79;
         6'd28: t = 7'd82;  6'd29: t = 7'd84;  6'd30: t = 7'd86;  6'd31: t = 7'd89;
         6'd32: t = 7'd91;  6'd33: t = 7'd93;  6'd34: t = 7'd95;  6'd35: t = 7'd97;
         6'd36: t = 7'd99;  6'd37: t = 7'd101; 6'd38: t = 7'd103; 6'd39: t = 7'd105;
         6'd40: t = 7'd106; 6'd41: t = 7'd108; 6'd42: t = 7'd110; 6'd43: t = 7'd111;
         6'd44: t = 7'd113; 6'd45: t = 7'd114; 6'd46: t = 7'd115; 6'd47: t = 7'd117;
         6'd48: t = 7'd118; 6'd49: t = 7'd119; 6'd50: t = 7'd120; 6'd51: t = 7'd121;
         6'd52: t = 7'd122; 6'd53: t = 7'd123; 6'd54: t = 7'd124; 6'd55: t = 7'd124;
         6'd56: t = 7'd125; 6'd57: t = 7'd125; 6'd58: t = 7'd126; 6'd59: t = 7'd126;
         default: t = 7'd127;
      endcase
      return t;
   endfunction

   logic [5:0] sin_idx;
   logic [6:0] sin_t;
   // Odd quadrants read the table backwards; 63-i is just ~i on six bits.
   assign sin_idx = rd_addr[6] ? ~rd_addr[5:0] : rd_addr[5:0];
   assign sin_t   = sin_quarter(sin_idx);
`endif

   assign wrap = (prev_addr_q == 8'hFF) && (rd_addr == 8'h00);

   // Configuration FSM: requests wait in the pending register until the address wraps.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      state_d    = state_q;
      act_wave_d = act_wave_q;
      act_amp_d  = act_amp_q;
      pnd_wave_d = pnd_wave_q;
      pnd_amp_d  = pnd_amp_q;
      case (state_q)
         RUN: begin
            if (cfg_req && wrap) begin
               act_wave_d = cfg_wave;
               act_amp_d  = cfg_amp;
            end else if (cfg_req) begin
               pnd_wave_d = cfg_wave;
               pnd_amp_d  = cfg_amp;
               state_d    = PEND;
            end
         end
         PEND: begin
            if (wrap) begin
               act_wave_d = cfg_req ? cfg_wave : pnd_wave_q;
               act_amp_d  = cfg_req ? cfg_amp  : pnd_amp_q;
               state_d    = RUN;
            end else if (cfg_req) begin
               pnd_wave_d = cfg_wave;
               pnd_amp_d  = cfg_amp;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Raw sample uses the next-state waveform so the wrap sample already sees the new setting.
   always_comb begin
      raw_s = 8'd128;
      case (act_wave_d)
`ifdef WAVE_SINE_EN
         2'd0: raw_s = rd_addr[7] ? (8'd127 - {1'b0, sin_t}) : (8'd128 + {1'b0, sin_t});
`else
         2'd0: raw_s = 8'd128;
`endif
         2'd1: raw_s = rd_addr[7] ? {~rd_addr[6:0], 1'b1} : {rd_addr[6:0], 1'b0};
         2'd2: raw_s = rd_addr;
         default: raw_s = rd_addr[7] ? 8'h00 : 8'hFF;
      endcase
   end

   // Flipping the MSB turns offset-binary s into two's-complement s-128 and back.
   assign dev_d  = raw_s ^ 8'h80;
   assign scaled = dev_q >>> amp1_q;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state_q     <= RUN;
         act_wave_q  <= DEF_WAVE;
         act_amp_q   <= DEF_AMP;
         pnd_wave_q  <= 2'd0;
         pnd_amp_q   <= 2'd0;
         prev_addr_q <= 8'h00;
         dev_q       <= 8'sd0;
         amp1_q      <= 2'd0;
         rd_data_q   <= 8'h80;
      end else begin
         state_q     <= state_d;
         act_wave_q  <= act_wave_d;
         act_amp_q   <= act_amp_d;
         pnd_wave_q  <= pnd_wave_d;
         pnd_amp_q   <= pnd_amp_d;
         prev_addr_q <= rd_addr;
         dev_q       <= dev_d;
         amp1_q      <= act_amp_d;
         rd_data_q   <= scaled ^ 8'h80;
      end
   end

   assign rd_data  = rd_data_q;
   assign cfg_pend = (state_q == PEND);
   assign act_wave = act_wave_q;
   assign act_amp  = act_amp_q;

endmodule

// File: tb/tb_wave_src.sv
// Directed bench for wave_src: reset, waveform/amplitude samples, deferred and coincident changes.
// Sine expectations follow WAVE_SINE_EN; without it waveform 0 reads as mid-scale.
module tb_wave_src;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rd_addr;
   logic       cfg_req;
   logic [1:0] cfg_wave;
   logic [1:0] cfg_amp;
   logic [7:0] rd_data;
   logic       cfg_pend;
   logic [1:0] act_wave;
   logic [1:0] act_amp;

   int n_vec = 0;
   int n_err = 0;

`ifdef WAVE_SINE_EN
   localparam logic [7:0] SIN_00 = 8'd130;
   localparam logic [7:0] SIN_40 = 8'd255;
   localparam logic [7:0] SIN_80 = 8'd125;
   localparam logic [7:0] SIN_30 = 8'd246;
   localparam logic [7:0] SIN_FF = 8'd125;
`else
   localparam logic [7:0] SIN_00 = 8'd128;
   localparam logic [7:0] SIN_40 = 8'd128;
   localparam logic [7:0] SIN_80 = 8'd128;
   localparam logic [7:0] SIN_30 = 8'd128;
   localparam logic [7:0] SIN_FF = 8'd128;
`endif

   wave_src #(.DEF_WAVE(2'd0), .DEF_AMP(2'd0)) dut (
      .clk      (clk),
      .rst      (rst),
      .rd_addr  (rd_addr),
      .cfg_req  (cfg_req),
      .cfg_wave (cfg_wave),
      .cfg_amp  (cfg_amp),
      .rd_data  (rd_data),
      .cfg_pend (cfg_pend),
      .act_wave (act_wave),
      .act_amp  (act_amp)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic request(input logic [1:0] w, input logic [1:0] a);
      cfg_req  = 1'b1;
      cfg_wave = w;
      cfg_amp  = a;
      step();
      cfg_req  = 1'b0;
   endtask

   task automatic sample(input string tag, input logic [7:0] addr, input logic [7:0] exp);
      rd_addr = addr;
      step();
      step();
      check(tag, rd_data, exp);
   endtask

   initial begin
      rst = 1'b1; rd_addr = 8'h00; cfg_req = 1'b0; cfg_wave = 2'd0; cfg_amp = 2'd0;
      repeat (3) step();
      check("rst_data", rd_data, 8'h80);
      check("rst_pend", {7'd0, cfg_pend}, 8'd0);
      check("rst_wave", {6'd0, act_wave}, 8'd0);
      check("rst_amp",  {6'd0, act_amp}, 8'd0);

      rst = 1'b0;
      step();
      check("post_rst_hold", rd_data, 8'h80);
      step();
      check("sine_00", rd_data, SIN_00);
      sample("sine_40", 8'h40, SIN_40);
      sample("sine_80", 8'h80, SIN_80);

      // Deferred change to square while sine is active.
      rd_addr = 8'h30;
      request(2'd3, 2'd0);
      check("defer_pend", {7'd0, cfg_pend}, 8'd1);
      check("defer_wave_held", {6'd0, act_wave}, 8'd0);
      step();
      check("defer_sine_30", rd_data, SIN_30);
      rd_addr = 8'hFF;
      step();
      check("defer_pend_ff", {7'd0, cfg_pend}, 8'd1);
      step();
      check("defer_sine_ff", rd_data, SIN_FF);
      rd_addr = 8'h00;
      step();
      check("wrap_wave", {6'd0, act_wave}, 8'd3);
      check("wrap_pend", {7'd0, cfg_pend}, 8'd0);
      step();
      check("wrap_sample", rd_data, 8'hFF);
      sample("square_80", 8'h80, 8'h00);

      // Request landing exactly on the wrap cycle: sawtooth, half amplitude.
      rd_addr = 8'hFF;
      step();
      rd_addr = 8'h00;
      request(2'd2, 2'd1);
      check("coin_pend", {7'd0, cfg_pend}, 8'd0);
      check("coin_wave", {6'd0, act_wave}, 8'd2);
      check("coin_amp",  {6'd0, act_amp}, 8'd1);
      step();
      check("saw_a1_00", rd_data, 8'd64);
      check("coin_pend2", {7'd0, cfg_pend}, 8'd0);
      sample("saw_a1_ff", 8'hFF, 8'd191);

      // Overwrite: triangle then sawtooth/amp2 before the wrap.
      rd_addr = 8'h10;
      request(2'd1, 2'd0);
      check("ovw_pend", {7'd0, cfg_pend}, 8'd1);
      step();
      request(2'd2, 2'd2);
      check("ovw_amp_held", {6'd0, act_amp}, 8'd1);
      rd_addr = 8'hFF;
      step();
      rd_addr = 8'h00;
      step();
      check("ovw_wave", {6'd0, act_wave}, 8'd2);
      check("ovw_amp",  {6'd0, act_amp}, 8'd2);
      check("ovw_pend0", {7'd0, cfg_pend}, 8'd0);

      // Held address 0x00: a request in the second held cycle must stay pending.
      request(2'd1, 2'd3);
      check("held_pend", {7'd0, cfg_pend}, 8'd1);
      check("held_wave", {6'd0, act_wave}, 8'd2);
      check("saw_a2_00", rd_data, 8'd96);
      step();
      step();
      check("held_pend_late", {7'd0, cfg_pend}, 8'd1);
      check("held_amp_late", {6'd0, act_amp}, 8'd2);
      rd_addr = 8'hFF;
      step();
      rd_addr = 8'h00;
      step();
      check("tri_wave", {6'd0, act_wave}, 8'd1);
      check("tri_amp",  {6'd0, act_amp}, 8'd3);
      step();
      check("tri_a3_00", rd_data, 8'd112);
      sample("tri_a3_7f", 8'h7F, 8'd143);
      sample("tri_a3_c0", 8'hC0, 8'd127);

      // Reset while a request is pending.
      rd_addr = 8'h20;
      request(2'd3, 2'd0);
      check("pre_rst_pend", {7'd0, cfg_pend}, 8'd1);
      rd_addr = 8'hFF;
      step();
      rst = 1'b1;
      step();
      check("mid_rst_pend", {7'd0, cfg_pend}, 8'd0);
      check("mid_rst_wave", {6'd0, act_wave}, 8'd0);
      check("mid_rst_amp",  {6'd0, act_amp}, 8'd0);
      check("mid_rst_data", rd_data, 8'h80);
      rst = 1'b0;
      rd_addr = 8'h00;
      request(2'd2, 2'd0);
      check("no_wrap_pend", {7'd0, cfg_pend}, 8'd1);
      check("no_wrap_wave", {6'd0, act_wave}, 8'd0);
      check("no_wrap_data", rd_data, 8'h80);
      step();
      check("post_rst_sine", rd_data, SIN_00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
